// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared constants for the 4-bit CPU datapath:
//   - MODE_W : width of the universal register operation select
//   - mode_e : operation encodings MODE_HOLD..MODE_DEC (0..7)
//   - DATA_W : default datapath width
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int MODE_W = 3;
    localparam int DATA_W = 4;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_ROR  = 3'd5,
        MODE_INC  = 3'd6,
        MODE_DEC  = 3'd7
    } mode_e;

endpackage

// File: rtl/univ_reg_next.sv
// ----------------------------------------------------------------------------
// univ_reg_next
// Purely combinational next-state logic for the universal register.
// Computes the next {co, q} from the current state and the operation inputs.
// Ports:
//   i_q     [WIDTH]  current register value
//   i_co    [1]      current carry flag (kept on HOLD)
//   i_d     [WIDTH]  parallel load data
//   i_si    [1]      serial input for SHL/SHR
//   i_mode  [MODE_W] operation select
//   o_q     [WIDTH]  next register value
//   o_co    [1]      next carry/borrow/shift-out flag
// ----------------------------------------------------------------------------
module univ_reg_next
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0]  i_q,
    input  logic              i_co,
    input  logic [WIDTH-1:0]  i_d,
    input  logic              i_si,
    input  logic [MODE_W-1:0] i_mode,
    output logic [WIDTH-1:0]  o_q,
    output logic              o_co
);

    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    // Increment is done one bit wider so the carry falls out of the sum.
    logic [WIDTH:0] w_inc;
    assign w_inc = {1'b0, i_q} + {1'b0, ONE_W};

    // Operation decode: next value and flag for every mode.
    always_comb begin
        o_q  = i_q;
        o_co = i_co;
        case (i_mode)
            MODE_HOLD: begin
                o_q  = i_q;
                o_co = i_co;
            end
            MODE_LOAD: begin
                o_q  = i_d;
                o_co = 1'b0;
            end
            MODE_SHL: begin
                o_q  = {i_q[WIDTH-2:0], i_si};
                o_co = i_q[WIDTH-1];
            end
            MODE_SHR: begin
                o_q  = {i_si, i_q[WIDTH-1:1]};
                o_co = i_q[0];
            end
            MODE_ROL: begin
                o_q  = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
                o_co = i_q[WIDTH-1];
            end
            MODE_ROR: begin
                o_q  = {i_q[0], i_q[WIDTH-1:1]};
                o_co = i_q[0];
            end
            MODE_INC: begin
                o_q  = w_inc[WIDTH-1:0];
                o_co = w_inc[WIDTH];
            end
            MODE_DEC: begin
                // Borrow only when decrementing from zero.
                o_q  = i_q - ONE_W;
                o_co = (i_q == ZERO_W) ? 1'b1 : 1'b0;
            end
            default: begin
                o_q  = i_q;
                o_co = i_co;
            end
        endcase
    end

endmodule

// File: rtl/univ_reg.sv
// ----------------------------------------------------------------------------
// univ_reg
// Parametrised edge-triggered universal register: hold, load, shift, rotate,
// increment and decrement with a registered carry flag.
// Ports:
//   clk    [1]      rising-edge clock
//   rst_n  [1]      asynchronous active-low reset (q=0, co=0)
//   clr    [1]      synchronous clear, priority over en/mode
//   en     [1]      operation enable; 0 holds all state
//   mode   [MODE_W] operation select (cpu_pkg::mode_e)
//   d      [WIDTH]  parallel load data
//   si     [1]      serial input for SHL/SHR
//   q      [WIDTH]  registered value
//   qb     [WIDTH]  ~q
//   so_l   [1]      q[WIDTH-1]
//   so_r   [1]      q[0]
//   co     [1]      registered carry/borrow/shift-out flag
//   z      [1]      q == 0
// qb, so_l, so_r and z are decoded from the flops only, so no input reaches
// an output without passing through a register.
// ----------------------------------------------------------------------------
module univ_reg
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              si,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  qb,
    output logic              so_l,
    output logic              so_r,
    output logic              co,
    output logic              z
);

    logic [WIDTH-1:0] r_q;
    logic             r_co;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_co_nxt;

    univ_reg_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .i_q    (r_q),
        .i_co   (r_co),
        .i_d    (d),
        .i_si   (si),
        .i_mode (mode),
        .o_q    (w_q_nxt),
        .o_co   (w_co_nxt)
    );

    // State register: async reset, then clear, then enabled update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q  <= {WIDTH{1'b0}};
            r_co <= 1'b0;
        end else if (clr) begin
            r_q  <= {WIDTH{1'b0}};
            r_co <= 1'b0;
        end else if (en) begin
            r_q  <= w_q_nxt;
            r_co <= w_co_nxt;
        end else begin
            r_q  <= r_q;
            r_co <= r_co;
        end
    end

    assign q    = r_q;
    assign co   = r_co;
    assign qb   = ~r_q;
    assign so_l = r_q[WIDTH-1];
    assign so_r = r_q[0];
    assign z    = (r_q == {WIDTH{1'b0}}) ? 1'b1 : 1'b0;

endmodule

// File: tb/tb_univ_reg.sv
// ----------------------------------------------------------------------------
// tb_univ_reg
// Self-checking bench for univ_reg (WIDTH=4): directed vector table,
// hand-written reset sequences and randomized traffic against an arithmetic
// reference model.
// ----------------------------------------------------------------------------
module tb_univ_reg;
    import cpu_pkg::*;

    localparam int W    = 4;
    localparam int M    = 16;   // 2**W
    localparam int HALF = 8;    // weight of the MSB

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             en;
    logic [MODE_W-1:0] mode;
    logic [W-1:0]     d;
    logic             si;
    logic [W-1:0]     q;
    logic [W-1:0]     qb;
    logic             so_l;
    logic             so_r;
    logic             co;
    logic             z;

    int total;
    int bad;

    // Reference model state as plain integers.
    int mq;
    int mco;

    univ_reg #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (en),
        .mode  (mode),
        .d     (d),
        .si    (si),
        .q     (q),
        .qb    (qb),
        .so_l  (so_l),
        .so_r  (so_r),
        .co    (co),
        .z     (z)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             clr;
        logic             en;
        logic [MODE_W-1:0] mode;
        logic [W-1:0]     d;
        logic             si;
        int               eq;
        int               eco;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every output against an expected register value and flag.
    task automatic chk_all(input string tag, input int eq, input int eco);
        chk({tag, ".q"},    int'(q),    eq);
        chk({tag, ".co"},   int'(co),   eco);
        chk({tag, ".qb"},   int'(qb),   M - 1 - eq);
        chk({tag, ".z"},    int'(z),    (eq == 0) ? 1 : 0);
        chk({tag, ".so_l"}, int'(so_l), eq / HALF);
        chk({tag, ".so_r"}, int'(so_r), eq % 2);
    endtask

    // Behavioural model: one clock edge with the given inputs.
    task automatic model_edge(input logic c, input logic e, input int md, input int dv, input int s);
        int t;
        if (c) begin
            mq = 0; mco = 0;
        end else if (e) begin
            case (md)
                0: begin end
                1: begin mq = dv; mco = 0; end
                2: begin mco = mq / HALF; mq = (mq * 2) % M + s; end
                3: begin mco = mq % 2; mq = mq / 2 + s * HALF; end
                4: begin mco = mq / HALF; mq = (mq * 2) % M + mco; end
                5: begin mco = mq % 2; mq = mq / 2 + mco * HALF; end
                6: begin t = mq + 1; mco = t / M; mq = t % M; end
                7: begin mco = (mq == 0) ? 1 : 0; mq = (mq + M - 1) % M; end
                default: begin end
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic c, input logic e, input mode_e md,
                                input logic [W-1:0] dv, input logic s,
                                input int eq, input int eco);
        vec_t v;
        v.clr = c; v.en = e; v.mode = md; v.d = dv; v.si = s;
        v.eq = eq; v.eco = eco;
        return v;
    endfunction

    initial begin
        total = 0; bad = 0;
        mq = 0; mco = 0;
        clr = 1'b0; en = 1'b0; mode = MODE_LOAD; d = 4'b1010; si = 1'b0;

        // Reset asserted with no clock edge yet.
        rst_n = 1'b0;
        #2;
        chk_all("reset", 0, 0);
        #1;
        rst_n = 1'b1;

        // Directed table covering hold, load, shift/rotate, wrap and priority.
        tbl.push_back(mk(1'b0, 1'b0, MODE_LOAD, 4'b1010, 1'b0, 0,  0));
        tbl.push_back(mk(1'b0, 1'b0, MODE_LOAD, 4'b1010, 1'b0, 0,  0));
        tbl.push_back(mk(1'b0, 1'b0, MODE_LOAD, 4'b1010, 1'b0, 0,  0));
        tbl.push_back(mk(1'b0, 1'b1, MODE_LOAD, 4'b1010, 1'b0, 10, 0));
        tbl.push_back(mk(1'b0, 1'b0, MODE_LOAD, 4'b0101, 1'b0, 10, 0));
        tbl.push_back(mk(1'b0, 1'b1, MODE_HOLD, 4'b0101, 1'b0, 10, 0));
        tbl.push_back(mk(1'b0, 1'b1, MODE_SHL,  4'b0000, 1'b1, 5,  1));
        tbl.push_back(mk(1'b0, 1'b0, MODE_SHL,  4'b0000, 1'b1, 5,  1));
        tbl.push_back(mk(1'b0, 1'b1, MODE_HOLD, 4'b0000, 1'b1, 5,  1));
        tbl.push_back(mk(1'b0, 1'b1, MODE_SHR,  4'b0000, 1'b0, 2,  1));
        tbl.push_back(mk(1'b0, 1'b1, MODE_ROL,  4'b0000, 1'b0, 4,  0));
        tbl.push_back(mk(1'b0, 1'b1, MODE_ROR,  4'b0000, 1'b0, 2,  0));
        tbl.push_back(mk(1'b0, 1'b1, MODE_LOAD, 4'b1110, 1'b0, 14, 0));
        tbl.push_back(mk(1'b0, 1'b1, MODE_INC,  4'b0000, 1'b0, 15, 0));
        tbl.push_back(mk(1'b0, 1'b1, MODE_INC,  4'b0000, 1'b0, 0,  1));
        tbl.push_back(mk(1'b0, 1'b1, MODE_DEC,  4'b0000, 1'b0, 15, 1));
        tbl.push_back(mk(1'b0, 1'b1, MODE_DEC,  4'b0000, 1'b0, 14, 0));
        tbl.push_back(mk(1'b0, 1'b1, MODE_LOAD, 4'b1111, 1'b0, 15, 0));
        tbl.push_back(mk(1'b1, 1'b1, MODE_LOAD, 4'b0110, 1'b0, 0,  0));
        tbl.push_back(mk(1'b0, 1'b0, MODE_INC,  4'b0110, 1'b0, 0,  0));

        foreach (tbl[i]) begin
            clr = tbl[i].clr; en = tbl[i].en; mode = tbl[i].mode;
            d = tbl[i].d; si = tbl[i].si;
            step();
            model_edge(tbl[i].clr, tbl[i].en, int'(tbl[i].mode), int'(tbl[i].d), int'(tbl[i].si));
            chk_all($sformatf("vec%0d", i), tbl[i].eq, tbl[i].eco);
        end

        // Reset in the middle of an INC stream.
        clr = 1'b1; en = 1'b0; step(); clr = 1'b0;
        en = 1'b1; mode = MODE_INC;
        for (int k = 0; k < 3; k++) step();
        chk_all("inc3", 3, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0);
        step();
        step();
        chk_all("rst_held", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_all("after_rst", 1, 0);
        mq = 1; mco = 0;

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            clr  = ($urandom_range(0, 15) == 0);
            en   = ($urandom_range(0, 3) != 0);
            mode = MODE_W'($urandom_range(0, 7));
            d    = W'($urandom_range(0, M - 1));
            si   = 1'($urandom_range(0, 1));
            step();
            model_edge(clr, en, int'(mode), int'(d), int'(si));
            chk_all($sformatf("rnd%0d", k), mq, mco);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
